load_unit: RTL and testbench

Data-memory read controller for the RV32I load path. Accepts one load request from the execute stage, performs a word-aligned read over a valid/ready memory handshake, then extracts and sign- or zero-extends the addressed byte, halfword or word. Stalls the pipeline while the read is outstanding and flags illegal, misaligned or timed-out loads.

---
 rtl/load_unit_if.sv | 10 +
 rtl/load_unit.sv | 124 ++++++++++++
 tb/tb_load_unit.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_unit_if.sv
// Memory read handshake between the load unit (master) and data memory (slave).
interface load_unit_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (output mem_req, output mem_addr, input mem_ready, input mem_rdata);
   modport slave  (input mem_req, input mem_addr, output mem_ready, output mem_rdata);
endinterface

// File: rtl/load_unit.sv
// RV32I load path controller: issues a word-aligned memory read, then extracts
// and sign/zero-extends the addressed byte, halfword or word.
module load_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  funct3,
   input  logic [31:0] address,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [31:0] result,
   load_unit_if.master mem
);
   localparam int CountWidth = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CountWidth-1:0] CountMax   = '1;
   localparam logic [CountWidth-1:0] CountLimit = CountWidth'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, WAIT, RESP, FAULT} state_t;

   state_t                state;
   state_t                state_next;
   logic [31:0]           addr_q;
   logic [2:0]            funct3_q;
   logic [CountWidth-1:0] wait_count;
   logic [CountWidth-1:0] count_next;
   logic [31:0]           result_q;
   logic                  start_legal;
   logic                  timeout_hit;

   function automatic logic is_legal(input logic [2:0] f3, input logic [1:0] lane);
      case (f3)
         3'b000, 3'b100: is_legal = 1'b1;
         3'b001, 3'b101: is_legal = ~lane[0];
         3'b010:         is_legal = (lane == 2'b00);
         default:        is_legal = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] word);
      logic [7:0]  byte_v;
      logic [15:0] half_v;
      byte_v = 8'(word >> {lane, 3'b000});
      half_v = 16'(word >> {lane[1], 4'b0000});
      case (f3)
         3'b000:  extract = {{24{byte_v[7]}}, byte_v};
         3'b001:  extract = {{16{half_v[15]}}, half_v};
         3'b100:  extract = {24'b0, byte_v};
         3'b101:  extract = {16'b0, half_v};
         default: extract = word;
      endcase
   endfunction

   always_comb begin
      start_legal = is_legal(funct3, address[1:0]);
      count_next  = (wait_count == CountMax) ? wait_count : wait_count + CountWidth'(1);
      timeout_hit = (TIMEOUT != 0) && (count_next == CountLimit);
   end

   // State register; reset drops mem_req at once since outputs decode from state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      busy        = 1'b0;
      done        = 1'b0;
      error       = 1'b0;
      mem.mem_req = 1'b0;
      case (state)
         IDLE, RESP, FAULT: begin
            done  = (state == RESP);
            error = (state == FAULT);
            if (start) begin
               state_next = start_legal ? WAIT : FAULT;
            end else begin
               state_next = IDLE;
            end
         end
         WAIT: begin
            busy        = 1'b1;
            mem.mem_req = 1'b1;
            if (mem.mem_ready) begin
               state_next = RESP;
            end else if (timeout_hit) begin
               state_next = FAULT;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Request latch, timeout counter and result capture; start cannot be accepted in WAIT.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr_q     <= '0;
         funct3_q   <= '0;
         wait_count <= '0;
         result_q   <= '0;
      end else begin
         if (start && state != WAIT && start_legal) begin
            addr_q     <= address;
            funct3_q   <= funct3;
            wait_count <= '0;
         end else if (state == WAIT && !mem.mem_ready) begin
            wait_count <= count_next;
         end
         if (state == WAIT && mem.mem_ready) begin
            result_q <= extract(funct3_q, addr_q[1:0], mem.mem_rdata);
         end
      end
   end

   assign mem.mem_addr = {addr_q[31:2], 2'b00};
   assign result       = result_q;
endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: directed vector table, multi-cycle corner sequences and
// randomized loads checked against an arithmetic reference model.
module tb_load_unit;
   localparam int TIMEOUT = 4;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] data;
      int          waits;
      logic [31:0] expResult;
      logic        expError;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] address;
   logic        busy;
   logic        done;
   logic        error;
   logic [31:0] result;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] lastResult  = '0;

   load_unit_if mem_bus();

   load_unit #(.TIMEOUT(TIMEOUT)) dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .funct3  (funct3),
      .address (address),
      .busy    (busy),
      .done    (done),
      .error   (error),
      .result  (result),
      .mem     (mem_bus)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic modelLegal(input logic [2:0] f3, input logic [31:0] addr);
      case (f3)
         3'b000, 3'b100: return 1'b1;
         3'b001, 3'b101: return (addr % 2) == 0;
         3'b010:         return (addr % 4) == 0;
         default:        return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] modelResult(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] data);
      logic [31:0] b;
      logic [31:0] h;
      b = (data >> (8 * (addr % 4))) & 32'hFF;
      h = (data >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
      case (f3)
         3'b000:  return (b >= 128) ? b - 32'd256 : b;
         3'b001:  return (h >= 32768) ? h - 32'd65536 : h;
         3'b100:  return b;
         3'b101:  return h;
         default: return data;
      endcase
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // One complete load from IDLE; waits >= TIMEOUT means memory never answers in time.
   task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                                input int waits, input logic [31:0] expResult, input logic expError);
      int stall;
      start   = 1'b1;
      funct3  = f3;
      address = addr;
      tick();
      start   = 1'b0;
      funct3  = 3'($urandom);
      address = $urandom;
      if (expError) begin
         checkOutput("illegal error", 32'(error), 1);
         checkOutput("illegal mem_req", 32'(mem_bus.mem_req), 0);
         checkOutput("illegal result held", result, lastResult);
         tick();
         checkOutput("illegal error width", 32'(error), 0);
         return;
      end
      stall = (waits < TIMEOUT) ? waits : TIMEOUT;
      for (int c = 0; c < stall; c++) begin
         checkOutput("wait busy", 32'(busy), 1);
         checkOutput("wait mem_req", 32'(mem_bus.mem_req), 1);
         checkOutput("wait mem_addr", mem_bus.mem_addr, addr & 32'hFFFF_FFFC);
         mem_bus.mem_ready = 1'b0;
         tick();
      end
      if (waits < TIMEOUT) begin
         checkOutput("ready mem_req", 32'(mem_bus.mem_req), 1);
         checkOutput("ready mem_addr", mem_bus.mem_addr, addr & 32'hFFFF_FFFC);
         mem_bus.mem_ready = 1'b1;
         mem_bus.mem_rdata = data;
         tick();
         mem_bus.mem_ready = 1'b0;
         mem_bus.mem_rdata = $urandom;
         checkOutput("resp done", 32'(done), 1);
         checkOutput("resp result", result, expResult);
         checkOutput("resp mem_req", 32'(mem_bus.mem_req), 0);
         lastResult = expResult;
      end else begin
         checkOutput("timeout error", 32'(error), 1);
         checkOutput("timeout mem_req", 32'(mem_bus.mem_req), 0);
         checkOutput("timeout done", 32'(done), 0);
         checkOutput("timeout result held", result, lastResult);
      end
      tick();
      checkOutput("idle done", 32'(done), 0);
      checkOutput("idle error", 32'(error), 0);
      checkOutput("idle busy", 32'(busy), 0);
   endtask

   initial begin
      vec_t table_v[14];
      logic [2:0]  rf3;
      logic [31:0] raddr;
      logic [31:0] rdata;
      int          rwaits;

      table_v[0]  = '{3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0};
      table_v[1]  = '{3'b000, 32'h0000_0103, 32'h8011_2233, 3, 32'hFFFF_FF80, 1'b0};
      table_v[2]  = '{3'b100, 32'h0000_0103, 32'h8011_2233, 3, 32'h0000_0080, 1'b0};
      table_v[3]  = '{3'b001, 32'h0000_0102, 32'h9ABC_0000, 1, 32'hFFFF_9ABC, 1'b0};
      table_v[4]  = '{3'b101, 32'h0000_0102, 32'h9ABC_0000, 2, 32'h0000_9ABC, 1'b0};
      table_v[5]  = '{3'b010, 32'h0000_0102, 32'h1234_5678, 0, 32'h0, 1'b1};
      table_v[6]  = '{3'b011, 32'h0000_0100, 32'h1234_5678, 0, 32'h0, 1'b1};
      table_v[7]  = '{3'b000, 32'h0000_0201, 32'h0000_7F00, 0, 32'h0000_007F, 1'b0};
      table_v[8]  = '{3'b001, 32'h0000_0200, 32'h1234_8001, 1, 32'hFFFF_8001, 1'b0};
      table_v[9]  = '{3'b101, 32'h0000_0201, 32'h1234_8001, 0, 32'h0, 1'b1};
      table_v[10] = '{3'b110, 32'h0000_0200, 32'h1234_8001, 0, 32'h0, 1'b1};
      table_v[11] = '{3'b111, 32'h0000_0204, 32'h1234_8001, 0, 32'h0, 1'b1};
      table_v[12] = '{3'b100, 32'h0000_0102, 32'h00AB_0000, 2, 32'h0000_00AB, 1'b0};
      table_v[13] = '{3'b010, 32'h0000_0104, 32'h5555_AAAA, 4, 32'h0, 1'b0};

      reset             = 1'b1;
      start             = 1'b0;
      funct3            = 3'b000;
      address           = 32'h0;
      mem_bus.mem_ready = 1'b0;
      mem_bus.mem_rdata = 32'h0;
      #12;
      checkOutput("reset busy", 32'(busy), 0);
      checkOutput("reset done", 32'(done), 0);
      checkOutput("reset error", 32'(error), 0);
      checkOutput("reset mem_req", 32'(mem_bus.mem_req), 0);
      checkOutput("reset mem_addr", mem_bus.mem_addr, 0);
      checkOutput("reset result", result, 0);
      tick();
      reset = 1'b0;
      tick();

      for (int i = 0; i < 14; i++) begin
         applyStimulus(table_v[i].f3, table_v[i].addr, table_v[i].data, table_v[i].waits,
                       table_v[i].expResult, table_v[i].expError);
      end

      // New load accepted during RESP follows without an idle bubble.
      start = 1'b1; funct3 = 3'b010; address = 32'h0000_0300;
      tick();
      start = 1'b0;
      checkOutput("b2b first mem_req", 32'(mem_bus.mem_req), 1);
      mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h1111_1111;
      tick();
      mem_bus.mem_ready = 1'b0;
      checkOutput("b2b first done", 32'(done), 1);
      checkOutput("b2b first result", result, 32'h1111_1111);
      start = 1'b1; funct3 = 3'b100; address = 32'h0000_0305;
      tick();
      start = 1'b0;
      checkOutput("b2b second mem_req", 32'(mem_bus.mem_req), 1);
      checkOutput("b2b second mem_addr", mem_bus.mem_addr, 32'h0000_0304);
      checkOutput("b2b no done", 32'(done), 0);
      mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h0000_CC00;
      tick();
      mem_bus.mem_ready = 1'b0;
      checkOutput("b2b second done", 32'(done), 1);
      checkOutput("b2b second result", result, 32'h0000_00CC);
      lastResult = 32'h0000_00CC;
      tick();

      // Timeout, then a new load accepted on the error cycle.
      start = 1'b1; funct3 = 3'b010; address = 32'h0000_0400;
      tick();
      start = 1'b0;
      for (int c = 0; c < TIMEOUT; c++) begin
         checkOutput("to mem_req", 32'(mem_bus.mem_req), 1);
         tick();
      end
      checkOutput("to error", 32'(error), 1);
      checkOutput("to mem_req low", 32'(mem_bus.mem_req), 0);
      start = 1'b1; funct3 = 3'b101; address = 32'h0000_0402;
      tick();
      start = 1'b0;
      checkOutput("to restart mem_req", 32'(mem_bus.mem_req), 1);
      checkOutput("to restart mem_addr", mem_bus.mem_addr, 32'h0000_0400);
      mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h7FFF_0000;
      tick();
      mem_bus.mem_ready = 1'b0;
      checkOutput("to restart done", 32'(done), 1);
      checkOutput("to restart result", result, 32'h0000_7FFF);
      lastResult = 32'h0000_7FFF;
      tick();

      // start during WAIT is ignored; the first request's address and type stay latched.
      start = 1'b1; funct3 = 3'b010; address = 32'h0000_0500;
      tick();
      funct3 = 3'b000; address = 32'h0000_0603;
      tick();
      start = 1'b0;
      checkOutput("ignore mem_addr", mem_bus.mem_addr, 32'h0000_0500);
      checkOutput("ignore busy", 32'(busy), 1);
      mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'hCAFE_F00D;
      tick();
      mem_bus.mem_ready = 1'b0;
      checkOutput("ignore done", 32'(done), 1);
      checkOutput("ignore result", result, 32'hCAFE_F00D);
      lastResult = 32'hCAFE_F00D;
      tick();

      // mem_ready while idle has no effect.
      mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h0BAD_0BAD;
      tick();
      tick();
      mem_bus.mem_ready = 1'b0;
      checkOutput("idle ready done", 32'(done), 0);
      checkOutput("idle ready result", result, lastResult);

      // Reset mid-WAIT drops mem_req between clock edges; a late mem_ready is ignored.
      start = 1'b1; funct3 = 3'b010; address = 32'h0000_0700;
      tick();
      start = 1'b0;
      checkOutput("rst pre mem_req", 32'(mem_bus.mem_req), 1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rst mem_req async", 32'(mem_bus.mem_req), 0);
      checkOutput("rst busy async", 32'(busy), 0);
      checkOutput("rst result cleared", result, 0);
      lastResult = 32'h0;
      tick();
      reset = 1'b0;
      mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h7777_7777;
      tick();
      mem_bus.mem_ready = 1'b0;
      checkOutput("rst late done", 32'(done), 0);
      checkOutput("rst late error", 32'(error), 0);
      tick();
      checkOutput("rst late done2", 32'(done), 0);
      checkOutput("rst late result", result, 0);

      for (int n = 0; n < 60; n++) begin
         rf3    = 3'($urandom_range(0, 7));
         raddr  = $urandom;
         rdata  = $urandom;
         rwaits = $urandom_range(0, TIMEOUT + 1);
         applyStimulus(rf3, raddr, rdata, rwaits, modelResult(rf3, raddr, rdata), !modelLegal(rf3, raddr));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
